// File: rtl/vram_cursor_writer.sv
// Text-mode VRAM writer: turns a character stream into VRAM writes at a blinking cursor,
// handling CR/LF/BS/FF control codes and a full-screen clear after reset.
module vram_cursor_writer #(
  parameter int              COLS      = 80,
  parameter int              ROWS      = 30,
  parameter int              DW        = 8,
  parameter int              AW        = 12,
  parameter logic [DW-1:0]   FILL      = 8'h20,
  parameter int              BLINK_DIV = 16_000_000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_char,
  input  logic          i_char_valid,
  output logic          o_char_ready,
  input  logic          i_clr,
  output logic [DW-1:0] o_vram_data,
  output logic [AW-1:0] o_vram_adr,
  output logic          o_vram_we,
  output logic [AW-1:0] o_cursor_adr,
  output logic          o_cursor_on,
  output logic          o_busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [AW-1:0] LAST_ADR   = AW'(CELLS - 1);
  localparam logic [AW-1:0] COLS_ADR   = AW'(COLS);
  localparam logic [AW-1:0] WRAP_ADR   = AW'((ROWS - 1) * COLS);
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_DIV - 1);

  localparam logic [DW-1:0] CH_BS    = DW'(8'h08);
  localparam logic [DW-1:0] CH_LF    = DW'(8'h0A);
  localparam logic [DW-1:0] CH_FF    = DW'(8'h0C);
  localparam logic [DW-1:0] CH_CR    = DW'(8'h0D);
  localparam logic [DW-1:0] CH_SPACE = DW'(8'h20);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_clrAdr;
  logic          r_vramWe;
  logic [AW-1:0] r_vramAdr;
  logic [DW-1:0] r_vramData;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_cursorAdr;
  logic [BW-1:0] r_blinkCnt;
  logic          r_cursorOn;

  logic w_ready;
  logic w_accept;
  logic w_printable;
  logic w_clrStart;
  logic w_clrDone;
  logic w_cursorEvent;

  assign w_ready       = (r_state == IDLE) && !i_clr;
  assign w_accept      = i_char_valid && w_ready;
  assign w_printable   = (i_char >= CH_SPACE);
  assign w_clrStart    = (r_state == IDLE) && (i_clr || (w_accept && (i_char == CH_FF)));
  // Every CLEAR cycle except the one straight after reset shows a fill write.
  assign w_clrDone     = r_vramWe && (r_vramAdr == LAST_ADR);
  assign w_cursorEvent = w_accept || w_clrStart;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= CLEAR;
      r_clrAdr   <= '0;
      r_vramWe   <= 1'b0;
      r_vramAdr  <= '0;
      r_vramData <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (w_clrDone) begin
            r_state  <= IDLE;
            r_vramWe <= 1'b0;
          end else begin
            r_vramWe   <= 1'b1;
            r_vramAdr  <= r_clrAdr;
            r_vramData <= FILL;
            r_clrAdr   <= r_clrAdr + AW'(1);
          end
        end
        IDLE: begin
          // Cell 0 is written on the entry edge so the clear takes exactly CELLS cycles.
          if (w_clrStart) begin
            r_state    <= CLEAR;
            r_vramWe   <= 1'b1;
            r_vramAdr  <= '0;
            r_vramData <= FILL;
            r_clrAdr   <= AW'(1);
          end else if (w_accept && w_printable) begin
            r_vramWe   <= 1'b1;
            r_vramAdr  <= r_cursorAdr;
            r_vramData <= i_char;
          end else begin
            r_vramWe <= 1'b0;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Column/row counters run alongside the linear address so no divide is ever needed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_cursorAdr <= '0;
    end else if (w_clrStart) begin
      r_col       <= '0;
      r_row       <= '0;
      r_cursorAdr <= '0;
    end else if (w_accept) begin
      if (w_printable) begin
        if (r_cursorAdr == LAST_ADR) begin
          r_col       <= '0;
          r_row       <= '0;
          r_cursorAdr <= '0;
        end else begin
          r_cursorAdr <= r_cursorAdr + AW'(1);
          if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
      end else begin
        case (i_char)
          CH_CR: begin
            r_col       <= '0;
            r_cursorAdr <= r_cursorAdr - AW'(r_col);
          end
          CH_LF: begin
            if (r_row == LAST_ROW) begin
              r_row       <= '0;
              r_cursorAdr <= r_cursorAdr - WRAP_ADR;
            end else begin
              r_row       <= r_row + RW'(1);
              r_cursorAdr <= r_cursorAdr + COLS_ADR;
            end
          end
          CH_BS: begin
            if (r_col != '0) begin
              r_col       <= r_col - CW'(1);
              r_cursorAdr <= r_cursorAdr - AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Typing keeps the cursor solid: any activity restarts the blink phase visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blinkCnt <= '0;
      r_cursorOn <= 1'b1;
    end else if (w_cursorEvent) begin
      r_blinkCnt <= '0;
      r_cursorOn <= 1'b1;
    end else if (r_blinkCnt == LAST_BLINK) begin
      r_blinkCnt <= '0;
      r_cursorOn <= ~r_cursorOn;
    end else begin
      r_blinkCnt <= r_blinkCnt + BW'(1);
    end
  end

  assign o_char_ready = w_ready;
  assign o_busy       = (r_state == CLEAR);
  assign o_vram_we    = r_vramWe;
  assign o_vram_adr   = r_vramAdr;
  assign o_vram_data  = r_vramData;
  assign o_cursor_adr = r_cursorAdr;
  assign o_cursor_on  = r_cursorOn;

endmodule

// File: doc/vram_cursor_writer.md
VRAM_CURSOR_WRITER -- requirements
Module: vram_cursor_writer

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROWS, default 30, text rows on screen.
REQ-003 Parameter DW, default 8, character/VRAM data width.
REQ-004 Parameter AW, default 12, VRAM/cursor address width; 2^AW SHALL be >= COLS*ROWS.
REQ-005 Parameter FILL, default 8'h20, character written by screen clear.
REQ-006 Parameter BLINK_DIV, default 16_000_000, clocks per cursor blink half-period.
REQ-007 i_clk  in  1  sole clock, all logic on rising edge.
REQ-008 i_rst  in  1  reset, asynchronous, active-high.
REQ-009 i_char  in  DW  character or control code.
REQ-010 i_char_valid  in  1  i_char valid this cycle.
REQ-011 o_char_ready  out  1  block accepts i_char this cycle.
REQ-012 i_clr  in  1  single-cycle clear-screen request.
REQ-013 o_vram_data  out  DW  VRAM write data.
REQ-014 o_vram_adr  out  AW  VRAM write address, linear row*COLS+col.
REQ-015 o_vram_we  out  1  VRAM write enable.
REQ-016 o_cursor_adr  out  AW  linear cursor position.
REQ-017 o_cursor_on  out  1  cursor visible (blink phase).
REQ-018 o_busy  out  1  high while screen clear in progress.

Function
REQ-019 States SHALL be CLEAR and IDLE only; o_busy = (state==CLEAR).
REQ-020 o_char_ready SHALL be (state==IDLE) && !i_clr, combinational; a character is accepted on i_char_valid && o_char_ready.
REQ-021 o_vram_data, o_vram_adr, o_vram_we, o_cursor_adr, o_cursor_on SHALL be registered outputs.
REQ-022 CLEAR: each cycle o_vram_we=1, o_vram_data=FILL, o_vram_adr counts 0..COLS*ROWS-1; after address COLS*ROWS-1 is written, next cycle o_vram_we=0 and state=IDLE; clear lasts exactly COLS*ROWS cycles.
REQ-023 Entering CLEAR SHALL set cursor to 0.
REQ-024 Printable character (i_char >= 8'h20) accepted in cycle N: cycle N+1 o_vram_we=1, o_vram_adr=old cursor, o_vram_data=i_char, cursor=old+1; from COLS*ROWS-1 cursor wraps to 0.
REQ-025 Throughput SHALL be one accepted character per cycle; back-to-back writes SHALL hold o_vram_we high continuously.
REQ-026 Cycles in IDLE with no printable character accepted SHALL drive o_vram_we=0.
REQ-027 8'h0D (CR): cursor to column 0 of current row; no VRAM write.
REQ-028 8'h0A (LF): cursor+COLS; from last row wraps to row 0, same column; no VRAM write.
REQ-029 8'h08 (BS): cursor-1 if column>0, else unchanged; no VRAM write.
REQ-030 8'h0C (FF): identical to i_clr; enter CLEAR next cycle.
REQ-031 Other codes below 8'h20 SHALL be accepted and ignored.
REQ-032 i_clr in IDLE SHALL enter CLEAR next cycle; simultaneous i_char_valid is not accepted (ready low); i_clr in CLEAR SHALL be ignored.
REQ-033 Blink counter counts 0..BLINK_DIV-1; at wrap o_cursor_on toggles.
REQ-034 Any accepted character or any cursor change SHALL force o_cursor_on=1 and restart the blink counter next cycle.
REQ-035 Cursor column/row arithmetic SHALL be done with internal column and row counters, no divider; o_cursor_adr = row*COLS+col.

Reset
REQ-036 While i_rst high: state=CLEAR, clear address 0, cursor 0, o_vram_we=0, o_vram_adr=0, o_vram_data=0, o_cursor_on=1, blink counter 0.
REQ-037 After i_rst falls, a full screen clear SHALL run from address 0; reset during clear or write aborts and restarts.

Verification
REQ-038 Reset release, COLS=4, ROWS=2 -> 8 cycles we=1, adr 0..7, data 8'h20, busy high; then busy=0, ready=1, cursor 0.
REQ-039 "A","B","C" back-to-back -> we high 3 cycles, adr 0,1,2, data 41,42,43; cursor 3.
REQ-040 Cursor 7 (last cell), send "Z" -> write adr 7; cursor 0; then LF from row 1 col 2 -> row 0 col 2, no write.
REQ-041 Cursor 5 (row1,col1): BS -> 4; BS -> 4 unchanged; CR -> 4; no writes.
REQ-042 i_clr with i_char_valid same cycle -> char not accepted, clear of 8 cells, cursor 0; i_clr mid-clear ignored.
REQ-043 BLINK_DIV=4, idle -> o_cursor_on toggles every 4 cycles; accepted char mid-phase -> o_cursor_on=1, counter restarts.
